alu_arb_seq: RTL and testbench

- Shares one instance of the team's combinational 32-bit ALU between two requesters, using round-robin arbitration.
- Sequences each operation and registers the result and flags, then returns them over a valid/ready response channel.
- Optionally adds a multi-cycle shift-add multiply that is built from repeated ALU ADD operations.
- Sits between the two issuing units and the shared ALU datapath.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu.sv | 36 +++
 rtl/alu_arb_seq_arb2_rr.sv | 17 +
 rtl/alu_arb_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_arb_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU sequencer: opcodes, FSM encoding, flag indices.
package alu_pkg;

  localparam logic [3:0] OP_SUB = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SLL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;

  localparam int FLG_EQ  = 0;
  localparam int FLG_SLT = 1;
  localparam int FLG_ULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Plain ALU ops are always legal; MUL only when the multiply feature is built in.
  function automatic logic op_is_legal(input logic [3:0] op, input logic mul_en);
    return (op[3] == 1'b0) || (mul_en && (op == OP_MUL));
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU. Flags compare a against b: {unsigned lt, signed lt, eq}.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       f
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] diff;

  always_comb begin
    diff       = {1'b0, a} - {1'b0, b};
    f[FLG_EQ]  = (a == b);
    f[FLG_SLT] = ($signed(a) < $signed(b));
    f[FLG_ULT] = diff[WIDTH];
    case (s)
      3'd0:    y = diff[WIDTH-1:0];
      3'd1:    y = a + b;
      3'd2:    y = a & b;
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = a >> b[SHW-1:0];
      3'd6:    y = a << b[SHW-1:0];
      3'd7:    y = $signed(a) >>> b[SHW-1:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb_seq_arb2_rr.sv
// Two-way round-robin grant: a lone requester wins; on contention the one not served last wins.
module arb2_rr (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arb_seq.sv
// Round-robin sequencer sharing one ALU between two requesters, with a valid/ready response.
// Define ALU_ARB_MUL_EN to add a WIDTH-cycle shift-add multiply (op 4'h8) built on ALU ADDs.
module alu_arb_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_y,
  output logic [2:0]       resp_f,
  output logic             resp_err,
  output logic             busy
);
  import alu_pkg::*;

`ifdef ALU_ARB_MUL_EN
  localparam logic MUL_EN = 1'b1;
  localparam int   CNT_W  = $clog2(WIDTH);
  logic [WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, mp_q, mp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             resp_valid_q, resp_valid_d, resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_y_q, resp_y_d;
  logic [2:0]       resp_f_q, resp_f_d;
  logic             resp_err_q, resp_err_d;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_s, alu_f;

  arb2_rr u_arb (.req(req_valid), .rr_last(rr_last_q), .gnt(gnt));

  alu #(.WIDTH(WIDTH)) u_alu (.a(alu_a), .b(alu_b), .s(alu_s), .y(alu_y), .f(alu_f));

  assign req_ready  = (rstn && (state_q == ST_IDLE)) ? gnt : 2'b00;
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_f     = resp_f_q;
  assign resp_err   = resp_err_q;

  // Outside multiply the ALU always sees the latched operands, keeping idle inputs deterministic.
  always_comb begin
`ifdef ALU_ARB_MUL_EN
    if (state_q == ST_MUL) begin
      alu_a = acc_q;
      alu_b = mc_q;
      alu_s = OP_ADD[2:0];
    end else begin
      alu_a = a_q;
      alu_b = b_q;
      alu_s = op_q[2:0];
    end
`else
    alu_a = a_q;
    alu_b = b_q;
    alu_s = op_q[2:0];
`endif
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_y_d     = resp_y_q;
    resp_f_d     = resp_f_q;
    resp_err_d   = resp_err_q;
`ifdef ALU_ARB_MUL_EN
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          a_d       = gnt[1] ? req1_a  : req0_a;
          b_d       = gnt[1] ? req1_b  : req0_b;
          op_d      = gnt[1] ? req1_op : req0_op;
          id_d      = gnt[1];
          rr_last_d = gnt[1];
`ifdef ALU_ARB_MUL_EN
          if (op_d == OP_MUL) begin
            state_d = ST_MUL;
            acc_d   = '0;
            mc_d    = a_d;
            mp_d    = b_d;
            cnt_d   = '0;
          end else begin
            state_d = ST_EXEC;
          end
`else
          state_d = ST_EXEC;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        if (op_is_legal(op_q, MUL_EN)) begin
          resp_y_d   = alu_y;
          resp_f_d   = (op_q == OP_SUB) ? alu_f : 3'b000;
          resp_err_d = 1'b0;
        end else begin
          resp_y_d   = '0;
          resp_f_d   = 3'b000;
          resp_err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_MUL: begin
`ifdef ALU_ARB_MUL_EN
        // One partial product per cycle: acc += mc whenever the current multiplier bit is set.
        acc_d = mp_q[0] ? alu_y : acc_q;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_y_d     = acc_d;
          resp_f_d     = 3'b000;
          resp_err_d   = 1'b0;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 4'h0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      resp_f_q     <= 3'b000;
      resp_err_q   <= 1'b0;
`ifdef ALU_ARB_MUL_EN
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_y_q     <= resp_y_d;
      resp_f_q     <= resp_f_d;
      resp_err_q   <= resp_err_d;
`ifdef ALU_ARB_MUL_EN
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arb_seq.sv
// Scoreboard bench for alu_arb_seq; expected responses are queued at accept and matched on handshake.
module tb_alu_arb_seq;

  typedef struct packed {
    logic        id;
    logic [31:0] y;
    logic [2:0]  f;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [3:0]  req0_op = 4'h0, req1_op = 4'h0;
  logic        resp_valid, resp_ready = 1'b1, resp_id, resp_err, busy;
  logic [31:0] resp_y;
  logic [2:0]  resp_f;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_arb_seq #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_y(resp_y), .resp_f(resp_f), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op);
    exp_t e;
    e = '0;
    e.id = id;
    case (op)
      4'h0: begin
        e.y = a - b;
        e.f = {a < b, $signed(a) < $signed(b), a == b};
      end
      4'h1: e.y = a + b;
      4'h2: e.y = a & b;
      4'h3: e.y = a | b;
      4'h4: e.y = a ^ b;
      4'h5: e.y = a >> b[4:0];
      4'h6: e.y = a << b[4:0];
      4'h7: e.y = $unsigned($signed(a) >>> b[4:0]);
`ifdef ALU_ARB_MUL_EN
      4'h8: e.y = a * b;
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Response monitor: every completed handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      chk_eq("resp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk_eq("resp_id", 64'(resp_id), 64'(mon_e.id));
        chk_eq("resp_y", 64'(resp_y), 64'(mon_e.y));
        chk_eq("resp_f", 64'(resp_f), 64'(mon_e.f));
        chk_eq("resp_err", 64'(resp_err), 64'(mon_e.err));
      end
    end
  end

  task automatic check_quiet_outputs(input string tag);
    chk_eq({tag, "_valid"}, 64'(resp_valid), 64'd0);
    chk_eq({tag, "_y"}, 64'(resp_y), 64'd0);
    chk_eq({tag, "_f_err_id"}, 64'({resp_f, resp_err, resp_id}), 64'd0);
    chk_eq({tag, "_busy"}, 64'(busy), 64'd0);
    chk_eq({tag, "_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk); #1;
    rstn       = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    sb.delete();
    #1;
    check_quiet_outputs(tag);
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_a = a; req0_b = b; req0_op = op;
    end
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk_eq("accept", 64'(req_ready[id]), 64'd1);
    if (req_ready[id]) sb.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_valid(input int lat);
    int n;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("latency", 64'(cyc - acc_cyc), 64'(lat));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         seen;
    logic       exp_g;
    logic       id;
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [3:0]  top [8];
    ta  = '{32'h80000000, 32'h12345678, 32'hF0F0F0F0, 32'hF0F0F0F0,
            32'hF0F0F0F0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF};
    tb  = '{32'h00000001, 32'h12345678, 32'h0FF00FF0, 32'h0FF00FF0,
            32'h0FF00FF0, 32'd31,       32'd31,       32'h00000001};
    top = '{4'h0, 4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h1};

    apply_reset("reset");

    send(1'b0, 32'd5, 32'd7, 4'h0, '{1'b0, 32'hFFFFFFFE, 3'b110, 1'b0});
    wait_valid(2);
    drain();

    for (int i = 0; i < 8; i++) begin
      id = 1'(i % 2);
      send(id, ta[i], tb[i], top[i], model(id, ta[i], tb[i], top[i]));
      wait_valid(2);
      drain();
    end

    // Contention from a fresh reset: requester 0 first, then strict alternation.
    apply_reset("reset_rr");
    @(negedge clk);
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'h1;
    req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'h1;
    req_valid = 2'b11;
    exp_g = 1'b0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      chk_eq("rr_grant", 64'(req_ready), exp_g ? 64'd2 : 64'd1);
      sb.push_back('{exp_g, 32'd2, 3'b000, 1'b0});
      exp_g = ~exp_g;
      @(posedge clk); #1;
      if (r == 2) req_valid = 2'b00;
      @(negedge clk);
    end
    drain();

    // Stalled response; a competing request must wait and then be served.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    send(1'b1, 32'h80000000, 32'd4, 4'h7, '{1'b1, 32'hF8000000, 3'b000, 1'b0});
    wait_valid(2);
    req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'h1;
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      chk_eq("stall_valid", 64'(resp_valid), 64'd1);
      chk_eq("stall_y", 64'(resp_y), 64'hF8000000);
      chk_eq("stall_id", 64'(resp_id), 64'd1);
      chk_eq("stall_ready", 64'(req_ready), 64'd0);
      chk_eq("stall_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("waiting_accept", 64'(req_ready[0]), 64'd1);
    sb.push_back('{1'b0, 32'd7, 3'b000, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    send(1'b0, 32'h1234, 32'h5678, 4'hA, '{1'b0, 32'd0, 3'b000, 1'b1});
    wait_valid(2);
    drain();

`ifdef ALU_ARB_MUL_EN
    send(1'b0, 32'd7, 32'd6, 4'h8, '{1'b0, 32'd42, 3'b000, 1'b0});
    wait_valid(33);
    drain();
    send(1'b1, 32'hFFFFFFFF, 32'd2, 4'h8, '{1'b1, 32'hFFFFFFFE, 3'b000, 1'b0});
    wait_valid(33);
    drain();
    send(1'b0, 32'd7, 32'd6, 4'h8, '{1'b0, 32'd42, 3'b000, 1'b0});
    repeat (8) @(posedge clk);
    apply_reset("abort_mul");
`else
    send(1'b0, 32'd7, 32'd6, 4'h8, '{1'b0, 32'd0, 3'b000, 1'b1});
    wait_valid(2);
    drain();
    @(posedge clk); #1;
    resp_ready = 1'b0;
    send(1'b0, 32'd9, 32'd3, 4'h0, '{1'b0, 32'd6, 3'b000, 1'b0});
    wait_valid(2);
    apply_reset("abort_done");
`endif

    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk_eq("no_resp_after_abort", 64'(seen), 64'd0);

    send(1'b1, 32'd9, 32'd9, 4'h0, '{1'b1, 32'd0, 3'b001, 1'b0});
    wait_valid(2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
